// File: rtl/serial_cmd_regfile.sv
// Byte-oriented command processor: NREG 8-bit control registers with
// write, read-back, full dump, firmware-version query, inter-byte timeout
// and a saturating protocol-error counter.
module serial_cmd_regfile #(
    parameter int unsigned          NREG       = 8,
    parameter logic [7:0]           FW_VERSION = 8'd3,
    parameter logic [NREG*8-1:0]    RESET_VALS = 64'h0000_0000_0000_090A,
    parameter logic [31:0]          TIMEOUT    = 32'd50_000_000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rxReady,
    input  logic [7:0]           rxData,
    input  logic                 txBusy,
    output logic                 txStart,
    output logic [7:0]           txData,
    output logic [NREG*8-1:0]    regs,
    output logic [NREG-1:0]      wr_strobe,
    output logic [7:0]           err_count
);

    localparam int unsigned AW        = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [8:0]  NREG9     = 9'(NREG);
    localparam logic [6:0]  LAST_DUMP = 7'(NREG - 1);

    localparam logic [7:0] CMD_VER   = 8'h00;
    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_READ  = 8'h02;
    localparam logic [7:0] CMD_DUMP  = 8'h03;

    typedef enum logic [2:0] {IDLE, ARGS, EXEC, TX, TXGAP} state_t;

    state_t         state, state_nx;
    logic [7:0]     cmd;
    logic [7:0]     arg0;
    logic [7:0]     arg1;
    logic           argcnt;
    logic [31:0]    tocnt;
    logic [6:0]     idx;
    logic [6:0]     last;
    logic [7:0]     reply;
    logic [7:0]     rf [NREG];

    logic [1:0]     err_add;
    logic [8:0]     err_sum;
    logic [7:0]     err_nx;
    logic           timeout;
    logic           last_arg;
    logic           addr_ok;
    logic [AW-1:0]  addr;

    assign timeout  = (state == ARGS) && (tocnt == TIMEOUT - 32'd1);
    assign last_arg = (cmd == CMD_READ) || argcnt;
    assign addr_ok  = ({1'b0, arg0} < NREG9);
    assign addr     = arg0[AW-1:0];
    assign err_sum  = {1'b0, err_count} + {7'b0, err_add};
    assign err_nx   = err_sum[8] ? 8'hFF : err_sum[7:0];

    for (genvar g = 0; g < NREG; g++) begin : g_flat
        assign regs[8*g +: 8] = rf[g];
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Next-state decode and per-cycle error contributions
    always_comb begin
        state_nx = state;
        err_add  = '0;
        case (state)
            IDLE: begin
                if (rxReady) begin
                    case (rxData)
                        CMD_VER, CMD_DUMP:   state_nx = EXEC;
                        CMD_WRITE, CMD_READ: state_nx = ARGS;
                        default:             err_add  = 2'd1;
                    endcase
                end
            end
            ARGS: begin
                // A byte arriving in the timeout cycle is discarded with the command.
                if (timeout) begin
                    state_nx = IDLE;
                    err_add  = 2'd1;
                end else if (rxReady && last_arg) begin
                    state_nx = EXEC;
                end
            end
            EXEC: begin
                if ((cmd == CMD_WRITE || cmd == CMD_READ) && !addr_ok) err_add = err_add + 2'd1;
                if (rxReady) err_add = err_add + 2'd1;
                state_nx = (cmd == CMD_WRITE) ? IDLE : TX;
            end
            TX: begin
                if (rxReady) err_add = 2'd1;
                if (!txBusy) state_nx = TXGAP;
            end
            TXGAP: begin
                if (rxReady) err_add = 2'd1;
                state_nx = (idx < last) ? TX : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: command/argument capture, register file, reply sequencing
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NREG; i++) rf[i] <= RESET_VALS[8*i +: 8];
            cmd       <= '0;
            arg0      <= '0;
            arg1      <= '0;
            argcnt    <= 1'b0;
            tocnt     <= '0;
            idx       <= '0;
            last      <= '0;
            reply     <= '0;
            txStart   <= 1'b0;
            txData    <= '0;
            wr_strobe <= '0;
            err_count <= '0;
        end else begin
            txStart   <= 1'b0;
            wr_strobe <= '0;
            err_count <= err_nx;
            case (state)
                IDLE: begin
                    if (rxReady) begin
                        cmd    <= rxData;
                        argcnt <= 1'b0;
                        tocnt  <= '0;
                    end
                end
                ARGS: begin
                    if (timeout) begin
                        tocnt <= '0;
                    end else if (rxReady) begin
                        tocnt  <= '0;
                        argcnt <= 1'b1;
                        if (!argcnt) arg0 <= rxData;
                        else         arg1 <= rxData;
                    end else begin
                        tocnt <= tocnt + 32'd1;
                    end
                end
                EXEC: begin
                    idx  <= '0;
                    last <= '0;
                    case (cmd)
                        CMD_VER:  reply <= FW_VERSION;
                        CMD_WRITE: begin
                            if (addr_ok) begin
                                rf[addr]        <= arg1;
                                wr_strobe[addr] <= 1'b1;
                            end
                        end
                        CMD_READ: reply <= addr_ok ? rf[addr] : 8'hEE;
                        CMD_DUMP: last  <= LAST_DUMP;
                        default: ;
                    endcase
                end
                TX: begin
                    // Registers cannot change while replying, so a live read of
                    // rf equals the snapshot taken at EXEC.
                    if (!txBusy) begin
                        txStart <= 1'b1;
                        txData  <= (cmd == CMD_DUMP) ? rf[idx[AW-1:0]] : reply;
                    end
                end
                TXGAP: begin
                    if (idx < last) idx <= idx + 7'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
